// File: rtl/ws_tile_sequencer_if.sv
// Host/core-facing bundle for ws_tile_sequencer: pass request, core instruction word and status.
// cycle_cnt exists only when WS_SEQ_STATS_EN is defined.
interface ws_tile_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] p_base;
  logic [ADDR_W-1:0] n_x;
  logic              ofifo_valid;
  logic [33:0]       inst;
  logic              xw_mode;
  logic [1:0]        pmem_mode;
  logic              busy;
  logic              done;
`ifdef WS_SEQ_STATS_EN
  logic [31:0]       cycle_cnt;

  modport master (
    output start, w_base, x_base, p_base, n_x, ofifo_valid,
    input  inst, xw_mode, pmem_mode, busy, done, cycle_cnt
  );
  modport slave (
    input  start, w_base, x_base, p_base, n_x, ofifo_valid,
    output inst, xw_mode, pmem_mode, busy, done, cycle_cnt
  );
`else
  modport master (
    output start, w_base, x_base, p_base, n_x, ofifo_valid,
    input  inst, xw_mode, pmem_mode, busy, done
  );
  modport slave (
    input  start, w_base, x_base, p_base, n_x, ofifo_valid,
    output inst, xw_mode, pmem_mode, busy, done
  );
`endif
endinterface

// File: rtl/ws_tile_sequencer.sv
// Weight-stationary tile sequencer: weight load, kernel load, activation load, execute, OFIFO drain.
// Optional busy-cycle counter on bus.cycle_cnt when WS_SEQ_STATS_EN is defined.
module ws_tile_sequencer #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  ws_tile_sequencer_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam logic [33:0]   IDLE_W = 34'h1_800C_0000;
  localparam logic [CW-1:0] ROW_C  = CW'(row);
  localparam logic [CW-1:0] COL_C  = CW'(col);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_KLOAD, S_GAP, S_XLOAD, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, rd_cnt, wr_cnt, n_e;
  logic [ADDR_W-1:0] w_b, x_b, p_b, n_q;
  logic [33:0]       inst_d;
  logic              xw_d, busy_d, done_d, rd_d, pw_d;

  assign n_e = {1'b0, n_q};

  // State, per-state cycle counter, captured pass parameters and drain counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_b    <= '0;
      x_b    <= '0;
      p_b    <= '0;
      n_q    <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + ONE;
      if (state == S_IDLE && bus.start) begin
        w_b <= bus.w_base;
        x_b <= bus.x_base;
        p_b <= bus.p_base;
        n_q <= bus.n_x;
      end
      if (state == S_IDLE) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_d) rd_cnt <= rd_cnt + ONE;
        if (pw_d) wr_cnt <= wr_cnt + ONE;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.start) state_n = (bus.n_x == '0) ? S_DONE : S_WLOAD;
      S_WLOAD: if (cnt == COL_C) state_n = S_KLOAD;
      S_KLOAD: if (cnt == ROW_C + COL_C - ONE) state_n = S_GAP;
      S_GAP:   state_n = S_XLOAD;
      S_XLOAD: if (cnt == n_e) state_n = S_EXEC;
      S_EXEC:  if (cnt == n_e + ROW_C + COL_C - ONE) state_n = S_DRAIN;
      S_DRAIN: if (pw_d && wr_cnt == n_e - ONE) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next-cycle output image. xmem data returns one cycle after the address,
  // so l0_wr trails the read window by one cycle (the tail cycle carries only l0_wr).
  // One OFIFO read is in flight at a time so ofifo_valid is re-sampled after each pop.
  always_comb begin
    inst_d = IDLE_W;
    xw_d   = 1'b0;
    busy_d = (state != S_IDLE) && (state != S_DONE);
    done_d = (state == S_DONE);
    rd_d   = 1'b0;
    pw_d   = 1'b0;
    case (state)
      S_WLOAD: begin
        xw_d = 1'b1;
        if (cnt < COL_C) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = w_b + cnt[ADDR_W-1:0];
        end
        if (cnt != '0) inst_d[2] = 1'b1;
      end
      S_KLOAD: begin
        xw_d      = 1'b1;
        inst_d[0] = 1'b1;
        inst_d[3] = 1'b1;
      end
      S_XLOAD: begin
        if (cnt < n_e) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = x_b + cnt[ADDR_W-1:0];
        end
        if (cnt != '0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        inst_d[1] = 1'b1;
        inst_d[3] = 1'b1;
      end
      S_DRAIN: begin
        rd_d      = bus.ofifo_valid && !bus.inst[6] && (rd_cnt < n_e);
        pw_d      = bus.inst[6];
        inst_d[6] = rd_d;
        if (pw_d) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = p_b + wr_cnt[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.inst      <= IDLE_W;
      bus.xw_mode   <= 1'b0;
      bus.pmem_mode <= 2'b00;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.inst      <= inst_d;
      bus.xw_mode   <= xw_d;
      bus.pmem_mode <= 2'b00;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
    end
  end

`ifdef WS_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.cycle_cnt <= '0;
    else if (state == S_IDLE && bus.start)
      bus.cycle_cnt <= '0;
    else if (bus.busy && bus.cycle_cnt != 32'hFFFF_FFFF)
      bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ws_tile_sequencer.sv
// Self-checking bench for ws_tile_sequencer: a negedge monitor condenses the instruction stream
// into address lists and counts, which each scenario compares with lists computed from the pass rules.
module tb_ws_tile_sequencer;
  localparam int AW = 11;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;

  ws_tile_sequencer_if #(.ADDR_W(AW)) bus();
  ws_tile_sequencer #(.row(ROW), .col(COL), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc, start_cyc, first_x_cyc, done_cyc, done_cnt, load_cnt, exec_cnt, busy_cyc;
  int l0_bad, const_bad, pm_bad, ofifo_bad, rd_seen, gap_left, ov_mode;
  bit mon_en = 1'b0;
  bit prev_xrd, prev_rd;
  logic [AW-1:0] xaddr_q[$];
  logic [AW-1:0] paddr_q[$];
  bit            xw_q[$];

  // Observes the stream and plays the OFIFO side: ofifo_valid only changes here, away from clk rise.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_xrd = 1'b0;
      prev_rd  = 1'b0;
      bus.ofifo_valid = 1'b1;
    end else begin
      cyc++;
      if (bus.start && start_cyc < 0) start_cyc = cyc;
      if (!bus.inst[19]) begin
        xaddr_q.push_back(bus.inst[17:7]);
        xw_q.push_back(bus.xw_mode);
        if (first_x_cyc < 0) first_x_cyc = cyc;
      end
      if (bus.inst[2] != prev_xrd) l0_bad++;
      if (bus.inst[33] || !bus.inst[18] || bus.pmem_mode != 2'b00 ||
          (bus.inst[0] && !bus.inst[3]) || (bus.inst[1] && !bus.inst[3])) const_bad++;
      load_cnt += int'(bus.inst[0]);
      exec_cnt += int'(bus.inst[1]);
      if (!bus.inst[32]) begin
        paddr_q.push_back(bus.inst[30:20]);
        if (bus.inst[31] || !prev_rd) pm_bad++;
      end else if (!bus.inst[31]) pm_bad++;
      if (bus.inst[6] && !bus.ofifo_valid) ofifo_bad++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.busy) busy_cyc++;
      prev_xrd = !bus.inst[19];
      prev_rd  = bus.inst[6];
      if (bus.inst[6]) rd_seen++;
      case (ov_mode)
        1: begin
          if (bus.inst[6] && rd_seen == 2) gap_left = 5;
          if (gap_left > 0) begin bus.ofifo_valid = 1'b0; gap_left--; end
          else bus.ofifo_valid = 1'b1;
        end
        2: bus.ofifo_valid = ($urandom_range(0, 2) != 0);
        default: bus.ofifo_valid = 1'b1;
      endcase
    end
  end

  task automatic clear_mon(input int mode);
    cyc = 0; start_cyc = -1; first_x_cyc = -1; done_cyc = -1; done_cnt = 0;
    load_cnt = 0; exec_cnt = 0; busy_cyc = 0; l0_bad = 0; const_bad = 0; pm_bad = 0;
    ofifo_bad = 0; rd_seen = 0; gap_left = 0; ov_mode = mode;
    xaddr_q.delete(); paddr_q.delete(); xw_q.delete();
    mon_en = 1'b1;
  endtask

  // One full pass: drive start, optionally re-pulse start during EXEC, then compare with the model.
  task automatic test_pass(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] p,
                           input logic [AW-1:0] n, input int mode, input bit inject, input string tag);
    logic [AW-1:0] ex[$];
    bit            ew[$];
    logic [AW-1:0] ep[$];
    int t, bad, nn;
    nn = int'(n);
    clear_mon(mode);
    @(posedge clk); #1;
    bus.w_base = w; bus.x_base = x; bus.p_base = p; bus.n_x = n; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.w_base = AW'($urandom); bus.x_base = AW'($urandom);
    bus.p_base = AW'($urandom); bus.n_x = AW'($urandom_range(1, 9));
    if (inject) begin
      t = 0;
      while (exec_cnt == 0 && t < 200) begin @(posedge clk); t++; end
      checks++;
      if (exec_cnt == 0) begin errors++; $display("FAIL %s exec_wait: no execute cycle within %0d cycles", tag, t); end
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 800) begin @(posedge clk); t++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL %s done_wait: no done within %0d cycles", tag, t); end
    repeat (12) @(posedge clk);
    #1;
    if (nn != 0) begin
      for (int c = 0; c < COL; c++) begin ex.push_back(w + AW'(c)); ew.push_back(1'b1); end
      for (int k = 0; k < nn; k++) begin ex.push_back(x + AW'(k)); ew.push_back(1'b0); end
      for (int i = 0; i < nn; i++) ep.push_back(p + AW'(i));
    end
    bad = 0;
    for (int i = 0; i < ex.size() && i < xaddr_q.size(); i++)
      if (xaddr_q[i] !== ex[i] || xw_q[i] !== ew[i]) bad++;
    checks++;
    if (xaddr_q.size() != ex.size() || bad != 0) begin
      errors++;
      $display("FAIL %s xmem_seq: got %0d reads (%0d wrong addr/xw_mode), need %0d", tag, xaddr_q.size(), bad, ex.size());
    end
    bad = 0;
    for (int i = 0; i < ep.size() && i < paddr_q.size(); i++)
      if (paddr_q[i] !== ep[i]) bad++;
    checks++;
    if (paddr_q.size() != ep.size() || bad != 0) begin
      errors++;
      $display("FAIL %s pmem_seq: got %0d writes (%0d wrong addr), need %0d", tag, paddr_q.size(), bad, ep.size());
    end
    checks++;
    if (load_cnt != ((nn != 0) ? ROW + COL : 0)) begin
      errors++; $display("FAIL %s load_cycles: got %0d need %0d", tag, load_cnt, (nn != 0) ? ROW + COL : 0);
    end
    checks++;
    if (exec_cnt != ((nn != 0) ? nn + ROW + COL : 0)) begin
      errors++; $display("FAIL %s exec_cycles: got %0d need %0d", tag, exec_cnt, (nn != 0) ? nn + ROW + COL : 0);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d need 1", tag, done_cnt); end
    checks++;
    if (l0_bad != 0 || const_bad != 0 || pm_bad != 0) begin
      errors++; $display("FAIL %s field_rules: l0_wr %0d const %0d pmem %0d violations, need 0", tag, l0_bad, const_bad, pm_bad);
    end
    checks++;
    if (ofifo_bad != 0) begin errors++; $display("FAIL %s ofifo_rd_when_empty: got %0d need 0", tag, ofifo_bad); end
    checks++;
    if (rd_seen != nn) begin errors++; $display("FAIL %s ofifo_reads: got %0d need %0d", tag, rd_seen, nn); end
    checks++;
    if (nn != 0 && first_x_cyc != start_cyc + 2) begin
      errors++; $display("FAIL %s first_read_latency: got %0d need %0d", tag, first_x_cyc - start_cyc, 2);
    end else if (nn == 0 && done_cyc != start_cyc + 2) begin
      errors++; $display("FAIL %s zero_n_done_latency: got %0d need %0d", tag, done_cyc - start_cyc, 2);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.inst !== IDLE_W) begin
      errors++; $display("FAIL %s idle_after: busy %b inst %h need 0 / %h", tag, bus.busy, bus.inst, IDLE_W);
    end
`ifdef WS_SEQ_STATS_EN
    checks++;
    if (bus.cycle_cnt !== 32'(busy_cyc)) begin
      errors++; $display("FAIL %s cycle_cnt: got %0d need %0d", tag, bus.cycle_cnt, busy_cyc);
    end
`endif
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    int t;
    bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.p_base = '0; bus.n_x = '0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.inst !== IDLE_W || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.xw_mode !== 1'b0 || bus.pmem_mode !== 2'b00) begin
      errors++; $display("FAIL reset_values: inst %h busy %b done %b xw %b pm %b need %h 0 0 0 00",
                         bus.inst, bus.busy, bus.done, bus.xw_mode, bus.pmem_mode, IDLE_W);
    end
`ifdef WS_SEQ_STATS_EN
    checks++;
    if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cycle_cnt: got %0d need 0", bus.cycle_cnt); end
`endif
    reset = 1'b0;
    clear_mon(0);
    @(posedge clk); #1;
    bus.w_base = 11'h10; bus.x_base = 11'h20; bus.p_base = 11'h30; bus.n_x = 11'd4; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    t = 0;
    while (!(first_x_cyc >= 0 && cyc >= first_x_cyc + 2) && t < 50) begin @(posedge clk); t++; end
    checks++;
    if (first_x_cyc < 0) begin errors++; $display("FAIL wload_wait: no weight read within %0d cycles", t); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.inst !== IDLE_W || bus.busy !== 1'b0 || bus.xw_mode !== 1'b0) begin
      errors++; $display("FAIL reset_abort: inst %h busy %b xw %b need %h 0 0", bus.inst, bus.busy, bus.xw_mode, IDLE_W);
    end
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_pass(11'h10, 11'h20, 11'h30, 11'd4, 0, 1'b0, "after_reset");
  endtask

  task automatic test_basic();
    test_pass(11'h10, 11'h20, 11'h30, 11'd4, 0, 1'b0, "basic");
  endtask

  task automatic test_ofifo_gap();
    test_pass(11'h10, 11'h20, 11'h30, 11'd4, 1, 1'b0, "ofifo_gap");
  endtask

  task automatic test_wrap();
    test_pass(11'h7FC, 11'h7FF, 11'h7FE, 11'd3, 0, 1'b0, "wrap");
  endtask

  task automatic test_zero_n();
    test_pass(11'h10, 11'h20, 11'h30, 11'd0, 0, 1'b0, "zero_n");
  endtask

  task automatic test_start_in_exec();
    test_pass(11'h100, 11'h200, 11'h300, 11'd5, 0, 1'b1, "start_in_exec");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      test_pass(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom_range(1, 6)),
                (i % 2 == 0) ? 2 : 0, 1'b0, $sformatf("random%0d", i));
  endtask

  task automatic test_back_to_back();
    test_pass(11'h7F8, 11'h005, 11'h7FF, 11'd2, 0, 1'b0, "b2b_a");
    test_pass(11'h001, 11'h7FD, 11'h000, 11'd1, 2, 1'b0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ofifo_gap();
    test_wrap();
    test_zero_n();
    test_start_in_exec();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
